rx_lane_bitslip_aligner: RTL

Synthesizable receive-side gearbox between the transceiver deserializers and `openhmc_top` on the parallel lane bus. Lets hard transceivers without native slip support drive `phy_data_rx_phy2link`. It applies per-lane bit slip on request from the link layer's `phy_bit_slip` and per-lane polarity inversion from `phy_lane_polarity`, then delivers aligned words at a fixed latency.

---
 rtl/rx_lane_slip.sv | 61 ++++++
 rtl/rx_lane_bitslip_aligner.sv | 46 ++++
 2 files changed

// File: rtl/rx_lane_slip.sv
`default_nettype none
// ============================================================================
// Module   : rx_lane_slip
// Brief    : Single-lane bit-slip and polarity slice: a two-word history window,
//            a modulo-LANE_WIDTH slip offset and a registered output mux.
// Revision : 1.0 - initial release
// ============================================================================
module rx_lane_slip #(
   parameter int LANE_WIDTH          = 64,
   parameter int BITSLIP_SHIFT_RIGHT = 1
) (
   input  logic                               clk,
   input  logic                               res_n,
   input  logic                               phy_rx_ready,
   input  logic [LANE_WIDTH-1:0]              data_in,
   input  logic                               bit_slip,
   input  logic                               lane_polarity,
   output logic [LANE_WIDTH-1:0]              data_out,
   output logic [$clog2(LANE_WIDTH)-1:0]      slip_offset
);

   localparam int LOG_LANE_WIDTH = $clog2(LANE_WIDTH);
   localparam logic [LOG_LANE_WIDTH-1:0] c_ONE = LOG_LANE_WIDTH'(1);

   logic [LANE_WIDTH-1:0]     r_cur;
   logic [LANE_WIDTH-1:0]     r_prev;
   logic [LOG_LANE_WIDTH-1:0] r_offset;
   logic [LANE_WIDTH-1:0]     r_data_out;
   logic [2*LANE_WIDTH-1:0]   w_window;
   logic [LANE_WIDTH-1:0]     w_slice;

   // Older word sits in the low half so offset 0 passes the stream straight through.
   assign w_window = {r_cur, r_prev};
   assign w_slice  = w_window[r_offset +: LANE_WIDTH];

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_cur      <= '0;
         r_prev     <= '0;
         r_offset   <= '0;
         r_data_out <= '0;
      end else if (!phy_rx_ready) begin
         r_cur      <= '0;
         r_prev     <= '0;
         r_offset   <= '0;
         r_data_out <= '0;
      end else begin
         r_cur      <= data_in;
         r_prev     <= r_cur;
         r_data_out <= w_slice ^ {LANE_WIDTH{lane_polarity}};
         if (bit_slip) begin
            r_offset <= (BITSLIP_SHIFT_RIGHT != 0) ? r_offset + c_ONE : r_offset - c_ONE;
         end
      end
   end

   assign data_out    = r_data_out;
   assign slip_offset = r_offset;

endmodule
`default_nettype wire

// File: rtl/rx_lane_bitslip_aligner.sv
`default_nettype none
// ============================================================================
// Module   : rx_lane_bitslip_aligner
// Brief    : Receive gearbox applying per-lane bit slip and polarity inversion
//            between the deserializers and the link layer parallel lane bus.
// Revision : 1.0 - initial release
// ============================================================================
module rx_lane_bitslip_aligner #(
   parameter int LOG_NUM_LANES       = 3,
   parameter int NUM_LANES           = 2**LOG_NUM_LANES,
   parameter int FPW                 = 4,
   parameter int DWIDTH              = 128*FPW,
   parameter int LANE_WIDTH          = DWIDTH/NUM_LANES,
   parameter int BITSLIP_SHIFT_RIGHT = 1
) (
   input  logic                                       clk,
   input  logic                                       res_n,
   input  logic                                       phy_rx_ready,
   input  logic [DWIDTH-1:0]                          data_in,
   input  logic [NUM_LANES-1:0]                       bit_slip,
   input  logic [NUM_LANES-1:0]                       lane_polarity,
   output logic [DWIDTH-1:0]                          data_out,
   output logic [NUM_LANES*$clog2(LANE_WIDTH)-1:0]    slip_offset
);

   localparam int LOG_LANE_WIDTH = $clog2(LANE_WIDTH);

   // Lanes are independent; deskew across lanes is left to the link layer.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      rx_lane_slip #(
         .LANE_WIDTH          (LANE_WIDTH),
         .BITSLIP_SHIFT_RIGHT (BITSLIP_SHIFT_RIGHT)
      ) u_slip (
         .clk           (clk),
         .res_n         (res_n),
         .phy_rx_ready  (phy_rx_ready),
         .data_in       (data_in[i*LANE_WIDTH +: LANE_WIDTH]),
         .bit_slip      (bit_slip[i]),
         .lane_polarity (lane_polarity[i]),
         .data_out      (data_out[i*LANE_WIDTH +: LANE_WIDTH]),
         .slip_offset   (slip_offset[i*LOG_LANE_WIDTH +: LOG_LANE_WIDTH])
      );
   end

endmodule
`default_nettype wire
